// File: rtl/rv32i_types.sv
// Shared RV32I types for the pipeline control slice.
// Contents: base opcode encodings, the pipeline_ctrl state encoding, the
// EX operand forward-select encoding, and opcode-format helper functions
// that say which register fields an instruction actually uses.
package rv32i_types;

   typedef enum logic [6:0] {
      OPC_LOAD     = 7'b0000011,
      OPC_MISC_MEM = 7'b0001111,
      OPC_OP_IMM   = 7'b0010011,
      OPC_AUIPC    = 7'b0010111,
      OPC_STORE    = 7'b0100011,
      OPC_OP       = 7'b0110011,
      OPC_LUI      = 7'b0110111,
      OPC_BRANCH   = 7'b1100011,
      OPC_JALR     = 7'b1100111,
      OPC_JAL      = 7'b1101111,
      OPC_SYSTEM   = 7'b1110011
   } opcode_e;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_IWAIT = 2'd1,
      ST_DWAIT = 2'd2,
      ST_REDIR = 2'd3
   } ctrl_state_e;

   typedef enum logic [1:0] {
      FWD_RF    = 2'd0,
      FWD_EXMEM = 2'd1,
      FWD_MEMWB = 2'd2
   } fwd_sel_e;

   localparam logic [4:0] REG_X0 = 5'd0;

   function automatic logic reads_rs1(input logic [6:0] opcode);
      return (opcode == OPC_OP)    || (opcode == OPC_OP_IMM) ||
             (opcode == OPC_LOAD)  || (opcode == OPC_STORE)  ||
             (opcode == OPC_BRANCH)|| (opcode == OPC_JALR);
   endfunction

   // Only R, S and B formats carry a real rs2; elsewhere those bits are
   // immediate and must not create false hazards.
   function automatic logic reads_rs2(input logic [6:0] opcode);
      return (opcode == OPC_OP) || (opcode == OPC_STORE) ||
             (opcode == OPC_BRANCH);
   endfunction

   function automatic logic writes_rd(input logic [6:0] opcode);
      return (opcode == OPC_OP)    || (opcode == OPC_OP_IMM) ||
             (opcode == OPC_LOAD)  || (opcode == OPC_LUI)    ||
             (opcode == OPC_AUIPC) || (opcode == OPC_JAL)    ||
             (opcode == OPC_JALR);
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational RAW / load-use detection and EX operand
// forward selection for the five-stage pipeline.
// Build option: PIPELINE_FWD_EN
//   defined   - EX/MEM and MEM/WB forwarding, stall only on load-use
//   undefined - no forwarding, stall on any RAW against ID/EX, EX/MEM, MEM/WB
// Ports:
//   id_opcode, id_rs1, id_rs2  in   decode-stage instruction
//   ex_opcode, ex_rd           in   ID/EX register
//   mem_opcode, mem_rd         in   EX/MEM register
//   wb_rd, wb_we               in   writeback destination / enable
//   hazard_stall               out  hold PC and IF/ID, bubble ID/EX
//   fwd_a, fwd_b               out  operand source select (fwd_sel_e)
module hazard_detect
   import rv32i_types::*;
(
   input  logic [6:0] id_opcode,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic [6:0] ex_opcode,
   input  logic [4:0] ex_rd,
   input  logic [6:0] mem_opcode,
   input  logic [4:0] mem_rd,
   input  logic [4:0] wb_rd,
   input  logic       wb_we,
   output logic       hazard_stall,
   output logic [1:0] fwd_a,
   output logic [1:0] fwd_b
);

   logic rs1_used;
   logic rs2_used;

   // x0 is hard-wired zero, so a read of x0 can never depend on anything.
   assign rs1_used = reads_rs1(id_opcode) && (id_rs1 != REG_X0);
   assign rs2_used = reads_rs2(id_opcode) && (id_rs2 != REG_X0);

`ifdef PIPELINE_FWD_EN

   logic     ex_is_load;
   logic     mem_fwd_ok;
   logic     wb_fwd_ok;
   fwd_sel_e sel_a;
   fwd_sel_e sel_b;

   // Load data does not exist until MEM completes, so EX/MEM cannot
   // forward it; that is exactly the case the load-use bubble covers.
   assign ex_is_load = (ex_opcode == OPC_LOAD) && (ex_rd != REG_X0);
   assign mem_fwd_ok = writes_rd(mem_opcode) && (mem_opcode != OPC_LOAD) &&
                       (mem_rd != REG_X0);
   assign wb_fwd_ok  = wb_we && (wb_rd != REG_X0);

   assign hazard_stall = ex_is_load &&
                         ((rs1_used && (id_rs1 == ex_rd)) ||
                          (rs2_used && (id_rs2 == ex_rd)));

   always_comb begin
      sel_a = FWD_RF;
      if (mem_fwd_ok && (mem_rd == id_rs1))
         sel_a = FWD_EXMEM;
      else if (wb_fwd_ok && (wb_rd == id_rs1))
         sel_a = FWD_MEMWB;
   end

   always_comb begin
      sel_b = FWD_RF;
      if (mem_fwd_ok && (mem_rd == id_rs2))
         sel_b = FWD_EXMEM;
      else if (wb_fwd_ok && (wb_rd == id_rs2))
         sel_b = FWD_MEMWB;
   end

   assign fwd_a = sel_a;
   assign fwd_b = sel_b;

`else

   logic ex_wr;
   logic mem_wr;
   logic wb_wr;
   logic raw_rs1;
   logic raw_rs2;

   assign ex_wr  = writes_rd(ex_opcode)  && (ex_rd  != REG_X0);
   assign mem_wr = writes_rd(mem_opcode) && (mem_rd != REG_X0);
   assign wb_wr  = wb_we && (wb_rd != REG_X0);

   // Without forwarding the regfile is the only source, so the consumer
   // waits until the producer has fully retired from writeback.
   assign raw_rs1 = rs1_used && ((ex_wr  && (ex_rd  == id_rs1)) ||
                                 (mem_wr && (mem_rd == id_rs1)) ||
                                 (wb_wr  && (wb_rd  == id_rs1)));
   assign raw_rs2 = rs2_used && ((ex_wr  && (ex_rd  == id_rs2)) ||
                                 (mem_wr && (mem_rd == id_rs2)) ||
                                 (wb_wr  && (wb_rd  == id_rs2)));

   assign hazard_stall = raw_rs1 || raw_rs2;
   assign fwd_a        = FWD_RF;
   assign fwd_b        = FWD_RF;

`endif

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall / flush / forward controller for a five-stage
// RV32I pipeline, with saturating stall and mispredict counters.
// Build option: PIPELINE_FWD_EN (selects forwarding inside hazard_detect).
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   id_*, ex_*, mem_*, wb_*          pipeline register fields
//   ex_mispredict                    EX branch/jump resolved against prediction
//   imem_read, imem_resp             instruction fetch handshake
//   dmem_req, dmem_resp              MEM-stage data handshake
//   load_pc .. load_mem_wb           register enables
//   flush_if_id, flush_id_ex         bubble insert on next load
//   fwd_a, fwd_b                     EX operand source select
//   stall_cnt, mispred_cnt           saturating performance counters
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_RUN   | normal issue, no long-latency operation outstanding
// ST_IWAIT | instruction fetch outstanding, front end holds
// ST_DWAIT | data access outstanding, whole pipeline frozen
// ST_REDIR | mispredict seen while fetch outstanding, redirect pending
module pipeline_ctrl
   import rv32i_types::*;
#(
   parameter int CTR_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       id_opcode,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [6:0]       ex_opcode,
   input  logic [4:0]       ex_rd,
   input  logic [6:0]       mem_opcode,
   input  logic [4:0]       mem_rd,
   input  logic [4:0]       wb_rd,
   input  logic             wb_we,
   input  logic             ex_mispredict,
   input  logic             imem_read,
   input  logic             imem_resp,
   input  logic             dmem_req,
   input  logic             dmem_resp,
   output logic             load_pc,
   output logic             load_if_id,
   output logic             load_id_ex,
   output logic             load_ex_mem,
   output logic             load_mem_wb,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CTR_W-1:0] stall_cnt,
   output logic [CTR_W-1:0] mispred_cnt
);

   ctrl_state_e      state_q;
   ctrl_state_e      state_d;
   logic             mp_pend_q;
   logic [CTR_W-1:0] stall_cnt_q;
   logic [CTR_W-1:0] mispred_cnt_q;

   logic       hazard_stall;
   logic [1:0] hd_fwd_a;
   logic [1:0] hd_fwd_b;

   logic in_redir;
   logic dstall;
   logic fstall;
   logic mp_now;
   logic redirect_now;
   logic redir_enter;
   logic redir_release;

   hazard_detect u_hazard_detect (
      .id_opcode    (id_opcode),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .ex_opcode    (ex_opcode),
      .ex_rd        (ex_rd),
      .mem_opcode   (mem_opcode),
      .mem_rd       (mem_rd),
      .wb_rd        (wb_rd),
      .wb_we        (wb_we),
      .hazard_stall (hazard_stall),
      .fwd_a        (hd_fwd_a),
      .fwd_b        (hd_fwd_b)
   );

   assign in_redir = (state_q == ST_REDIR);

   // A response in the same cycle releases the stall, so the response
   // cycle itself is a normal advancing cycle.
   assign dstall = ((state_q == ST_DWAIT) || dmem_req) && !dmem_resp;
   assign fstall = ((state_q == ST_IWAIT) || in_redir || imem_read) && !imem_resp;

   // A mispredict raised while frozen is remembered and acted on in the
   // first unfrozen cycle, whether or not EX still presents it.
   assign mp_now        = !dstall && !in_redir && (ex_mispredict || mp_pend_q);
   assign redirect_now  = mp_now && !fstall;
   assign redir_enter   = mp_now && fstall;
   assign redir_release = in_redir && !dstall && imem_resp;

   always_comb begin
      load_pc     = 1'b1;
      load_if_id  = 1'b1;
      load_id_ex  = 1'b1;
      load_ex_mem = 1'b1;
      load_mem_wb = 1'b1;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      if (!rst_n) begin
         load_pc     = 1'b0;
         load_if_id  = 1'b0;
         load_id_ex  = 1'b0;
         load_ex_mem = 1'b0;
         load_mem_wb = 1'b0;
         flush_if_id = 1'b1;
         flush_id_ex = 1'b1;
      end else if (dstall) begin
         load_pc     = 1'b0;
         load_if_id  = 1'b0;
         load_id_ex  = 1'b0;
         load_ex_mem = 1'b0;
         load_mem_wb = 1'b0;
      end else if (redirect_now || redir_release) begin
         flush_if_id = 1'b1;
         flush_id_ex = 1'b1;
      end else if (redir_enter) begin
         // Mispredicting instruction moves on to EX/MEM; the front end
         // freezes until the fetch in flight returns.
         load_pc     = 1'b0;
         load_if_id  = 1'b0;
         load_id_ex  = 1'b0;
         flush_if_id = 1'b1;
      end else if (in_redir) begin
         load_pc     = 1'b0;
         load_if_id  = 1'b0;
         load_id_ex  = 1'b0;
         load_ex_mem = 1'b0;
         flush_if_id = 1'b1;
      end else if (hazard_stall) begin
         load_pc     = 1'b0;
         load_if_id  = 1'b0;
         flush_id_ex = 1'b1;
      end else if (fstall) begin
         load_pc     = 1'b0;
         load_if_id  = 1'b0;
         flush_if_id = 1'b1;
      end
   end

   assign fwd_a = rst_n ? hd_fwd_a : FWD_RF;
   assign fwd_b = rst_n ? hd_fwd_b : FWD_RF;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN, ST_DWAIT: begin
            if (dstall)
               state_d = ST_DWAIT;
            else if (redir_enter)
               state_d = ST_REDIR;
            else if (fstall)
               state_d = ST_IWAIT;
            else
               state_d = ST_RUN;
         end
         ST_IWAIT: begin
            if (redir_enter)
               state_d = ST_REDIR;
            else if (!fstall)
               state_d = ST_RUN;
         end
         ST_REDIR: begin
            if (redir_release)
               state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_RUN;
         mp_pend_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (dstall && !in_redir && ex_mispredict)
            mp_pend_q <= 1'b1;
         else if (!dstall)
            mp_pend_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q   <= '0;
         mispred_cnt_q <= '0;
      end else begin
         if (!load_pc && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CTR_W'(1);
         if (mp_now && (mispred_cnt_q != '1))
            mispred_cnt_q <= mispred_cnt_q + CTR_W'(1);
      end
   end

   assign stall_cnt   = stall_cnt_q;
   assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl. Expected values are hand-computed;
// where PIPELINE_FWD_EN changes behaviour both expectations are listed.
module tb_pipeline_ctrl;
   import rv32i_types::*;

`ifdef PIPELINE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic [6:0]  id_opcode;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic [6:0]  ex_opcode;
   logic [4:0]  ex_rd;
   logic [6:0]  mem_opcode;
   logic [4:0]  mem_rd;
   logic [4:0]  wb_rd;
   logic        wb_we;
   logic        ex_mispredict;
   logic        imem_read;
   logic        imem_resp;
   logic        dmem_req;
   logic        dmem_resp;
   logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
   logic        flush_if_id, flush_id_ex;
   logic [1:0]  fwd_a, fwd_b;
   logic [31:0] stall_cnt, mispred_cnt;

   logic [4:0]  loads;
   logic [1:0]  flushes;
   int          n_checks;
   int          n_fail;

   assign loads   = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb};
   assign flushes = {flush_if_id, flush_id_ex};

   pipeline_ctrl #(.CTR_W(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .id_opcode     (id_opcode),
      .id_rs1        (id_rs1),
      .id_rs2        (id_rs2),
      .ex_opcode     (ex_opcode),
      .ex_rd         (ex_rd),
      .mem_opcode    (mem_opcode),
      .mem_rd        (mem_rd),
      .wb_rd         (wb_rd),
      .wb_we         (wb_we),
      .ex_mispredict (ex_mispredict),
      .imem_read     (imem_read),
      .imem_resp     (imem_resp),
      .dmem_req      (dmem_req),
      .dmem_resp     (dmem_resp),
      .load_pc       (load_pc),
      .load_if_id    (load_if_id),
      .load_id_ex    (load_id_ex),
      .load_ex_mem   (load_ex_mem),
      .load_mem_wb   (load_mem_wb),
      .flush_if_id   (flush_if_id),
      .flush_id_ex   (flush_id_ex),
      .fwd_a         (fwd_a),
      .fwd_b         (fwd_b),
      .stall_cnt     (stall_cnt),
      .mispred_cnt   (mispred_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_idle();
      id_opcode     = OPC_OP_IMM;
      id_rs1        = 5'd0;
      id_rs2        = 5'd0;
      ex_opcode     = OPC_OP_IMM;
      ex_rd         = 5'd0;
      mem_opcode    = OPC_OP_IMM;
      mem_rd        = 5'd0;
      wb_rd         = 5'd0;
      wb_we         = 1'b0;
      ex_mispredict = 1'b0;
      imem_read     = 1'b0;
      imem_resp     = 1'b0;
      dmem_req      = 1'b0;
      dmem_resp     = 1'b0;
   endtask

   // Step to just after the next rising edge so new inputs are applied
   // well clear of the edge; checks then happen at the falling edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      set_idle();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_loads",   loads, 5'b00000);
      check_eq("rst_flush",   flushes, 2'b11);
      check_eq("rst_fwd_a",   fwd_a, 2'd0);
      check_eq("rst_fwd_b",   fwd_b, 2'd0);
      check_eq("rst_stall",   stall_cnt, 32'd0);
      check_eq("rst_mispred", mispred_cnt, 32'd0);

      cyc();
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("run_loads", loads, 5'b11111);
      check_eq("run_flush", flushes, 2'b00);

      // data stall, response low for four cycles
      for (int i = 0; i < 4; i++) begin
         cyc();
         dmem_req = 1'b1;
         @(negedge clk);
         check_eq($sformatf("dstall_loads_%0d", i), loads, 5'b00000);
         check_eq($sformatf("dstall_flush_%0d", i), flushes, 2'b00);
      end
      cyc();
      dmem_resp = 1'b1;
      @(negedge clk);
      check_eq("dresp_loads", loads, 5'b11111);
      check_eq("dresp_stall_cnt", stall_cnt, 32'd4);

      // mispredict with no fetch outstanding
      cyc();
      set_idle();
      ex_mispredict = 1'b1;
      @(negedge clk);
      check_eq("mp_loads", loads, 5'b11111);
      check_eq("mp_flush", flushes, 2'b11);
      cyc();
      set_idle();
      @(negedge clk);
      check_eq("mp_cnt1", mispred_cnt, 32'd1);
      check_eq("mp_flush_clear", flushes, 2'b00);

      // mispredict with fetch outstanding, response after three cycles
      cyc();
      ex_mispredict = 1'b1;
      imem_read     = 1'b1;
      @(negedge clk);
      check_eq("redir0_loads", loads, 5'b00011);
      check_eq("redir0_flush", flushes, 2'b10);
      for (int i = 1; i < 3; i++) begin
         cyc();
         ex_mispredict = 1'b0;
         @(negedge clk);
         check_eq($sformatf("redir%0d_loads", i), loads, 5'b00001);
         check_eq($sformatf("redir%0d_flush", i), flushes, 2'b10);
      end
      cyc();
      imem_resp = 1'b1;
      @(negedge clk);
      check_eq("redir_resp_loads", loads, 5'b11111);
      check_eq("redir_resp_flush", flushes, 2'b11);
      cyc();
      set_idle();
      @(negedge clk);
      check_eq("redir_done_flush", flushes, 2'b00);
      check_eq("mp_cnt2", mispred_cnt, 32'd2);
      check_eq("stall_cnt7", stall_cnt, 32'd7);

      // mispredict raised during a data stall
      cyc();
      dmem_req      = 1'b1;
      ex_mispredict = 1'b1;
      @(negedge clk);
      check_eq("dmp0_loads", loads, 5'b00000);
      check_eq("dmp0_flush", flushes, 2'b00);
      cyc();
      ex_mispredict = 1'b0;
      @(negedge clk);
      check_eq("dmp1_flush", flushes, 2'b00);
      check_eq("dmp1_mp_cnt", mispred_cnt, 32'd2);
      cyc();
      dmem_resp = 1'b1;
      @(negedge clk);
      check_eq("dmp_rel_loads", loads, 5'b11111);
      check_eq("dmp_rel_flush", flushes, 2'b11);
      cyc();
      set_idle();
      @(negedge clk);
      check_eq("mp_cnt3", mispred_cnt, 32'd3);
      check_eq("stall_cnt9", stall_cnt, 32'd9);
      check_eq("dmp_after_flush", flushes, 2'b00);

      // x0 is never a hazard or a forward source
      cyc();
      id_opcode  = OPC_OP;  id_rs1 = 5'd0; id_rs2 = 5'd1;
      mem_opcode = OPC_OP;  mem_rd = 5'd0;
      wb_we      = 1'b1;    wb_rd  = 5'd0;
      @(negedge clk);
      check_eq("x0_fwd_a", fwd_a, 2'd0);
      check_eq("x0_loads", loads, 5'b11111);

      // ADD x3 then SUB x4,x3,x2
      cyc();
      set_idle();
      id_opcode = OPC_OP; id_rs1 = 5'd3; id_rs2 = 5'd2;
      ex_opcode = OPC_OP; ex_rd  = 5'd3;
      @(negedge clk);
      check_eq("raw_ex_loads", loads, FWD ? 5'b11111 : 5'b00111);
      check_eq("raw_ex_flush", flushes, FWD ? 2'b00 : 2'b01);
      cyc();
      ex_opcode  = OPC_OP_IMM; ex_rd = 5'd0;
      mem_opcode = OPC_OP;     mem_rd = 5'd3;
      @(negedge clk);
      check_eq("raw_mem_loads", loads, FWD ? 5'b11111 : 5'b00111);
      check_eq("raw_mem_fwd_a", fwd_a, FWD ? 2'd1 : 2'd0);
      cyc();
      mem_opcode = OPC_OP_IMM; mem_rd = 5'd0;
      wb_we      = 1'b1;       wb_rd  = 5'd3;
      @(negedge clk);
      check_eq("raw_wb_loads", loads, FWD ? 5'b11111 : 5'b00111);
      check_eq("raw_wb_fwd_a", fwd_a, FWD ? 2'd2 : 2'd0);
      cyc();
      wb_we = 1'b0;
      @(negedge clk);
      check_eq("raw_clear_loads", loads, 5'b11111);
      check_eq("raw_clear_fwd_a", fwd_a, 2'd0);
      cyc();
      set_idle();
      @(negedge clk);
      check_eq("raw_stall_cnt", stall_cnt, FWD ? 32'd9 : 32'd12);

      // load x5 in EX, ADD x6,x5,x1 in ID
      cyc();
      id_opcode = OPC_OP;   id_rs1 = 5'd5; id_rs2 = 5'd1;
      ex_opcode = OPC_LOAD; ex_rd  = 5'd5;
      @(negedge clk);
      check_eq("lu_loads", loads, 5'b00111);
      check_eq("lu_flush", flushes, 2'b01);
      cyc();
      ex_opcode = OPC_OP_IMM; ex_rd = 5'd0;
      wb_we     = 1'b1;       wb_rd = 5'd5;
      @(negedge clk);
      check_eq("lu_next_fwd_a", fwd_a, FWD ? 2'd2 : 2'd0);
      check_eq("lu_next_loads", loads, FWD ? 5'b11111 : 5'b00111);

      // I-type: rs2 field is immediate, must not match the load
      cyc();
      set_idle();
      id_opcode = OPC_OP_IMM; id_rs1 = 5'd7; id_rs2 = 5'd5;
      ex_opcode = OPC_LOAD;   ex_rd  = 5'd5;
      @(negedge clk);
      check_eq("itype_rs2_loads", loads, 5'b11111);

      // EX/MEM wins over MEM/WB for the same register
      cyc();
      set_idle();
      id_opcode  = OPC_OP; id_rs1 = 5'd8; id_rs2 = 5'd9;
      mem_opcode = OPC_OP; mem_rd = 5'd9;
      wb_we      = 1'b1;   wb_rd  = 5'd9;
      @(negedge clk);
      check_eq("prio_fwd_b", fwd_b, FWD ? 2'd1 : 2'd0);
      check_eq("prio_fwd_a", fwd_a, 2'd0);

      // fetch stall for two cycles
      for (int i = 0; i < 2; i++) begin
         cyc();
         set_idle();
         imem_read = 1'b1;
         @(negedge clk);
         check_eq($sformatf("iwait%0d_loads", i), loads, 5'b00111);
         check_eq($sformatf("iwait%0d_flush", i), flushes, 2'b10);
      end
      cyc();
      imem_resp = 1'b1;
      @(negedge clk);
      check_eq("iresp_loads", loads, 5'b11111);
      cyc();
      set_idle();
      @(negedge clk);
      check_eq("iwait_stall_cnt", stall_cnt, FWD ? 32'd12 : 32'd17);

      // reset in the middle of a data stall
      cyc();
      dmem_req = 1'b1;
      @(negedge clk);
      cyc();
      #1 rst_n = 1'b0;
      #1;
      check_eq("mrst_loads",   loads, 5'b00000);
      check_eq("mrst_flush",   flushes, 2'b11);
      check_eq("mrst_fwd_a",   fwd_a, 2'd0);
      check_eq("mrst_stall",   stall_cnt, 32'd0);
      check_eq("mrst_mispred", mispred_cnt, 32'd0);
      cyc();
      set_idle();
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("mrst_run_loads", loads, 5'b11111);
      check_eq("mrst_run_flush", flushes, 2'b00);
      cyc();
      @(negedge clk);
      check_eq("mrst_run_stall", stall_cnt, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
